// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ sources, each with valid/addr/data, and a one-hot ready back.
// Requesters use the master modport and the arbiter uses the slave modport.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single reg_file write port, with a pending-write scoreboard.
// Optional RF_WB_ARB_PERF_EN adds a saturating count of cycles with two or more requesters valid.
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5
) (
  input  logic              clk,
  input  logic              reset,
  rf_wb_arbiter_if.slave    req,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_addr,
  output logic [31:0]       busy,
`ifdef RF_WB_ARB_PERF_EN
  output logic [31:0]       conflict_cnt,
`endif
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [XLEN-1:0]   wr_data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [31:0]     busy_q, busy_d;

  logic [NUM_REQ-1:0] ready;
  logic               gnt_found;
  logic [PtrW-1:0]    gnt_idx;
  logic               handshake;
  logic [AW-1:0]      gnt_addr;
  logic [XLEN-1:0]    gnt_data;

  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = (int'(base) + off) % NUM_REQ;
    return sum[PtrW-1:0];
  endfunction

  // Scan upward from the pointer; the first valid index wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!gnt_found && req.req_valid[wrap_idx(ptr_q, off)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(ptr_q, off);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (gnt_found && !reset) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  assign req.req_ready = ready;
  assign handshake     = |(req.req_valid & ready);

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        gnt_addr = req.req_addr[i*AW +: AW];
        gnt_data = req.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // An x0 grant releases the requester but never reaches reg_file.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (handshake && (gnt_addr != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = gnt_addr;
      wr_data_d = gnt_data;
    end
  end

  // Clear on the reg_file commit edge, then apply the claim so a same-edge claim wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (claim_valid) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

`ifdef RF_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] n_valid;

  always_comb begin
    n_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + {31'd0, req.req_valid[i]};
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((n_valid >= 32'd2) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
